// File: rtl/cam_capture.sv
// Camera capture front end: pairs RGB565 bytes framed by VSYNC/HREF, decimates the frame
// and emits an RGB332 pixel stream straight into the frame-buffer RAM.
module cam_capture #(
  parameter int unsigned bitsPixel = 8,
  parameter int unsigned srcWidth  = 640,
  parameter int unsigned srcHeight = 480,
  parameter int unsigned decimH    = 4,
  parameter int unsigned decimV    = 4,
  parameter int unsigned numPixel  = (srcWidth / decimH) * (srcHeight / decimV)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_vsync,
  input  logic                 i_href,
  input  logic [7:0]           i_data,
  output logic                 o_DV,
  output logic [bitsPixel-1:0] o_pixel,
  output logic                 o_frameDone,
  output logic                 o_frameErr
);

  localparam int unsigned ColW = (srcWidth > 1) ? $clog2(srcWidth) : 1;
  localparam int unsigned RowW = (srcHeight > 1) ? $clog2(srcHeight) : 1;
  localparam int unsigned CntW = $clog2(numPixel + 1);
  localparam int unsigned DhW  = (decimH > 1) ? $clog2(decimH) : 1;
  localparam int unsigned DvW  = (decimV > 1) ? $clog2(decimV) : 1;

  localparam logic [ColW-1:0] ColMax = ColW'(srcWidth - 1);
  localparam logic [RowW-1:0] RowMax = RowW'(srcHeight - 1);
  localparam logic [CntW-1:0] NumPix = CntW'(numPixel);
  localparam logic [DhW-1:0]  DhMax  = DhW'(decimH - 1);
  localparam logic [DvW-1:0]  DvMax  = DvW'(decimV - 1);

  typedef enum logic [1:0] {StWaitVsync, StWaitFrame, StActive} state_e;

  state_e          state_q;
  logic            vsync_q, href_q;
  logic            phase_q;
  logic [5:0]      hi_bits_q;   // only the R[4:2] and G[5:3] bits of the high byte
  logic [ColW-1:0] col_q;
  logic [DhW-1:0]  col_mod_q;
  logic            col_full_q;
  logic [RowW-1:0] row_q;
  logic [DvW-1:0]  row_mod_q;
  logic [CntW-1:0] out_cnt_q;
  logic            overrun_q;

  logic vs_rise, vs_fall, href_fall, keep;

  always_comb begin
    vs_rise   = i_vsync & ~vsync_q;
    vs_fall   = ~i_vsync & vsync_q;
    href_fall = ~i_href & href_q;
    keep      = (col_mod_q == '0) && (row_mod_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StWaitVsync;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      phase_q     <= 1'b0;
      hi_bits_q   <= '0;
      col_q       <= '0;
      col_mod_q   <= '0;
      col_full_q  <= 1'b0;
      row_q       <= '0;
      row_mod_q   <= '0;
      out_cnt_q   <= '0;
      overrun_q   <= 1'b0;
      o_DV        <= 1'b0;
      o_pixel     <= '0;
      o_frameDone <= 1'b0;
      o_frameErr  <= 1'b0;
    end else begin
      vsync_q     <= i_vsync;
      href_q      <= i_href;
      o_DV        <= 1'b0;
      o_frameDone <= 1'b0;
      o_frameErr  <= 1'b0;

      unique case (state_q)
        StWaitVsync: begin
          if (i_vsync) state_q <= StWaitFrame;
        end

        StWaitFrame: begin
          if (vs_fall) begin
            state_q    <= StActive;
            phase_q    <= 1'b0;
            col_q      <= '0;
            col_mod_q  <= '0;
            col_full_q <= 1'b0;
            row_q      <= '0;
            row_mod_q  <= '0;
            out_cnt_q  <= '0;
            overrun_q  <= 1'b0;
          end
        end

        StActive: begin
          // A vsync rise closes the frame and wins over any byte on the same cycle.
          if (vs_rise) begin
            state_q     <= StWaitFrame;
            o_frameDone <= 1'b1;
            o_frameErr  <= (out_cnt_q != NumPix) || overrun_q;
          end else if (i_href) begin
            if (!col_full_q) begin
              if (!phase_q) begin
                hi_bits_q <= {i_data[7:5], i_data[2:0]};
                phase_q   <= 1'b1;
              end else begin
                phase_q <= 1'b0;
                if (keep) begin
                  // Never write past the frame buffer; remember the overrun instead.
                  if (out_cnt_q < NumPix) begin
                    o_DV      <= 1'b1;
                    o_pixel   <= bitsPixel'({hi_bits_q, i_data[4:3]});
                    out_cnt_q <= out_cnt_q + 1'b1;
                  end else begin
                    overrun_q <= 1'b1;
                  end
                end
                if (col_q == ColMax) col_full_q <= 1'b1;
                else                 col_q      <= col_q + 1'b1;
                col_mod_q <= (col_mod_q == DhMax) ? '0 : col_mod_q + 1'b1;
              end
            end
          end else if (href_fall) begin
            phase_q    <= 1'b0;
            col_q      <= '0;
            col_mod_q  <= '0;
            col_full_q <= 1'b0;
            if (row_q != RowMax) row_q <= row_q + 1'b1;
            // The line-modulus keeps running past the last line so oversize frames overrun.
            row_mod_q <= (row_mod_q == DvMax) ? '0 : row_mod_q + 1'b1;
          end
        end

        default: state_q <= StWaitVsync;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
// Scoreboard bench for cam_capture on a reduced frame geometry: the driver pushes expected
// pixels and frame-end flags, a negedge monitor pops and compares them.
module tb_cam_capture;

  localparam int unsigned W  = 40;
  localparam int unsigned H  = 24;
  localparam int unsigned DH = 4;
  localparam int unsigned DV = 2;
  localparam int unsigned NP = (W / DH) * (H / DV);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_vsync = 1'b0;
  logic       i_href = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       o_DV;
  logic [7:0] o_pixel;
  logic       o_frameDone;
  logic       o_frameErr;

  always #5 clk = ~clk;

  cam_capture #(
    .bitsPixel(8),
    .srcWidth (W),
    .srcHeight(H),
    .decimH   (DH),
    .decimV   (DV),
    .numPixel (NP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_vsync    (i_vsync),
    .i_href     (i_href),
    .i_data     (i_data),
    .o_DV       (o_DV),
    .o_pixel    (o_pixel),
    .o_frameDone(o_frameDone),
    .o_frameErr (o_frameErr)
  );

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] pix_q[$];
  bit         frame_q[$];
  bit         capturing = 1'b0;
  int         emitted = 0;
  bit         overrun = 1'b0;
  int         line_idx = 0;
  bit         prev_dv = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Split into RGB565 channels, keep the top bits of each.
  function automatic logic [7:0] rgb332(input logic [7:0] hi, input logic [7:0] lo);
    int r5, g6, b5;
    r5 = int'(hi) >> 3;
    g6 = ((int'(hi) & 7) << 3) | (int'(lo) >> 5);
    b5 = int'(lo) & 31;
    return 8'(((r5 >> 2) << 5) | ((g6 >> 3) << 2) | (b5 >> 3));
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_DV) begin
        check("dv_not_back_to_back", int'(prev_dv), 0);
        check("dv_was_expected", int'(pix_q.size() > 0), 1);
        if (pix_q.size() > 0) check("pixel", int'(o_pixel), int'(pix_q.pop_front()));
      end
      if (o_frameDone) begin
        check("done_was_expected", int'(frame_q.size() > 0), 1);
        if (frame_q.size() > 0) check("frame_err", int'(o_frameErr), int'(frame_q.pop_front()));
      end else if (o_frameErr) begin
        check("err_needs_done", int'(o_frameDone), 1);
      end
      prev_dv = o_DV;
    end else begin
      prev_dv = 1'b0;
    end
  end

  task automatic send_bytes(input int nbytes, input int mode);
    logic [7:0] hi, lo, cb;
    int c;
    for (int b = 0; b < nbytes; b++) begin
      c  = b / 2;
      cb = 8'(c);
      if (b % 2 == 0) begin
        case (mode)
          0: begin hi = 8'hE5; lo = 8'h18; end
          1: begin hi = {cb[4:2], 2'b00, cb[7:5]}; lo = {3'b000, cb[1:0], 3'b000}; end
          default: begin hi = 8'($urandom); lo = 8'($urandom); end
        endcase
      end
      @(negedge clk);
      i_href = 1'b1;
      i_data = (b % 2 == 0) ? hi : lo;
      if (b % 2 == 1 && capturing && c < int'(W) &&
          line_idx % int'(DV) == 0 && c % int'(DH) == 0) begin
        if (emitted < int'(NP)) begin
          pix_q.push_back(rgb332(hi, lo));
          emitted++;
        end else begin
          overrun = 1'b1;
        end
      end
    end
  endtask

  task automatic send_line(input int nbytes, input int mode);
    send_bytes(nbytes, mode);
    @(negedge clk);
    i_href = 1'b0;
    repeat (4) @(negedge clk);
    line_idx++;
  endtask

  task automatic send_frame(input int nlines, input int mode);
    for (int r = 0; r < nlines; r++) send_line(2 * int'(W), mode);
  endtask

  task automatic vsync_pulse(input bit href_too);
    @(negedge clk);
    i_vsync = 1'b1;
    if (href_too) begin
      i_href = 1'b1;
      i_data = 8'h18;
    end
    if (capturing) frame_q.push_back((emitted != int'(NP)) || overrun);
    @(negedge clk);
    i_href = 1'b0;
    repeat (2) @(negedge clk);
    i_vsync = 1'b0;
    repeat (3) @(negedge clk);
    check("frame_end_reported", frame_q.size(), 0);
    check("pixels_drained", pix_q.size(), 0);
    capturing = 1'b1;
    emitted   = 0;
    overrun   = 1'b0;
    line_idx  = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_dv", int'(o_DV), 0);
    check("reset_pixel", int'(o_pixel), 0);
    check("reset_done", int'(o_frameDone), 0);
    check("reset_err", int'(o_frameErr), 0);

    // Release mid-frame: nothing may come out until a vsync high-low sequence.
    rst_n = 1'b1;
    for (int r = 0; r < 3; r++) send_line(2 * int'(W), 2);
    vsync_pulse(1'b0);

    send_frame(int'(H), 0);
    vsync_pulse(1'b0);
    send_frame(int'(H), 1);
    vsync_pulse(1'b0);
    send_frame(int'(H), 2);
    vsync_pulse(1'b0);

    send_frame(16, 2);   // short frame
    vsync_pulse(1'b0);
    send_frame(30, 2);   // long frame, overruns
    vsync_pulse(1'b0);

    // Odd, exact and overlong lines.
    for (int r = 0; r < int'(H); r++) begin
      case (r % 3)
        0:       send_line(2 * int'(W) - 1, 2);
        1:       send_line(2 * int'(W), 2);
        default: send_line(2 * int'(W) + 6, 2);
      endcase
    end
    vsync_pulse(1'b0);

    // Low byte of a kept pixel arrives together with the vsync rise: dropped.
    send_line(2 * int'(W), 2);
    send_line(2 * int'(W), 2);
    send_bytes(1, 0);
    vsync_pulse(1'b1);

    // Asynchronous reset right after a kept pixel strobes.
    send_line(2 * int'(W), 0);
    send_line(2 * int'(W), 0);
    send_bytes(2, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_dv", int'(o_DV), 0);
    check("async_reset_pixel", int'(o_pixel), 0);
    check("async_reset_done", int'(o_frameDone), 0);
    check("async_reset_err", int'(o_frameErr), 0);
    i_href = 1'b0;
    pix_q.delete();
    frame_q.delete();
    capturing = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 2; r++) send_line(2 * int'(W), 2);
    vsync_pulse(1'b0);
    send_frame(int'(H), 2);
    vsync_pulse(1'b0);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
